keypad_scan: RTL and testbench

//  Matrix keypad scanner: input-side counterpart of the 7-seg LED multiplexer. Drives one-cold

---
 rtl/keypad_scan.sv | 170 +++++++++++++++++
 tb/tb_keypad_scan.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: one-cold column strobe, 2-flop row sync, press/release debounce, one code per press.
// Key valid 1 clock after the deciding sample; no backpressure, an unacked key blocks new codes and sets sticky overrun.
module keypad_scan #(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4,
   localparam int CW      = $clog2(ROWS*COLS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] row_in,
   output logic [COLS-1:0] col_sel,
   input  logic            key_ack,
   output logic [CW-1:0]   key_code,
   output logic            key_valid,
   output logic            overrun
);

   localparam int RW  = $clog2(ROWS);
   localparam int CLW = $clog2(COLS);
   localparam int DW  = $clog2(SCAN_DIV);
   localparam int NW  = $clog2(DEBOUNCE+1);

   typedef enum logic [1:0] {S_SCAN, S_DEB, S_HELD} state_t;

   state_t          r_state;
   logic [ROWS-1:0] r_meta;
   logic [ROWS-1:0] r_rs;
   logic [DW-1:0]   r_dwell;
   logic [CLW-1:0]  r_col;
   logic [COLS-1:0] r_col_sel;
   logic [RW-1:0]   r_row;
   logic [NW-1:0]   r_pcnt;
   logic [NW-1:0]   r_rcnt;
   logic [CW-1:0]   r_key_code;
   logic            r_key_valid;
   logic            r_overrun;

   logic            w_sample;
   logic            w_any_low;
   logic            w_row_low;
   logic [RW-1:0]   w_low_row;
   logic [CLW-1:0]  w_col_next;
   logic            w_emit;
   logic            w_adv;
   logic [RW-1:0]   w_emit_row;
   logic [CW-1:0]   w_code;

   assign w_sample   = (r_dwell == DW'(SCAN_DIV-1));
   assign w_any_low  = ~&r_rs;
   assign w_row_low  = ~r_rs[r_row];
   assign w_col_next = (r_col == CLW'(COLS-1)) ? '0 : r_col + CLW'(1);
   assign w_code     = CW'(32'(w_emit_row) * COLS + 32'(r_col));

   // Descending loop so the lowest low row index wins.
   always_comb begin
      w_low_row = '0;
      for (int i = ROWS-1; i >= 0; i--) begin
         if (!r_rs[i]) w_low_row = RW'(i);
      end
   end

   always_comb begin
      w_emit     = 1'b0;
      w_adv      = 1'b0;
      w_emit_row = r_row;
      if (w_sample) begin
         case (r_state)
            S_SCAN: begin
               if (w_any_low) begin
                  w_emit_row = w_low_row;
                  w_emit     = (DEBOUNCE == 1);
               end else begin
                  w_adv = 1'b1;
               end
            end
            S_DEB: begin
               if (w_row_low) w_emit = (r_pcnt == NW'(DEBOUNCE-1));
               else           w_adv  = 1'b1;
            end
            S_HELD: begin
               if (!w_row_low && (r_rcnt == NW'(DEBOUNCE-1))) w_adv = 1'b1;
            end
            default: w_adv = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_SCAN;
         r_meta      <= '1;
         r_rs        <= '1;
         r_dwell     <= '0;
         r_col       <= '0;
         r_col_sel   <= ~COLS'(1);
         r_row       <= '0;
         r_pcnt      <= '0;
         r_rcnt      <= '0;
         r_key_code  <= '0;
         r_key_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_meta  <= row_in;
         r_rs    <= r_meta;
         r_dwell <= w_sample ? '0 : r_dwell + DW'(1);

         if (w_adv) begin
            r_col     <= w_col_next;
            r_col_sel <= ~(COLS'(1) << w_col_next);
         end

         if (w_sample) begin
            case (r_state)
               S_SCAN: begin
                  if (w_any_low) begin
                     r_row   <= w_low_row;
                     r_pcnt  <= NW'(1);
                     r_rcnt  <= '0;
                     r_state <= (DEBOUNCE == 1) ? S_HELD : S_DEB;
                  end
               end
               S_DEB: begin
                  if (w_row_low) begin
                     r_pcnt <= r_pcnt + NW'(1);
                     if (w_emit) begin
                        r_state <= S_HELD;
                        r_rcnt  <= '0;
                     end
                  end else begin
                     r_state <= S_SCAN;
                  end
               end
               S_HELD: begin
                  if (w_row_low) begin
                     r_rcnt <= '0;
                  end else if (w_adv) begin
                     r_rcnt  <= '0;
                     r_state <= S_SCAN;
                  end else begin
                     r_rcnt <= r_rcnt + NW'(1);
                  end
               end
               default: r_state <= S_SCAN;
            endcase
         end

         // An ack in the emit cycle frees the slot, so the new code loads and overrun clears.
         if (w_emit) begin
            if (!r_key_valid || key_ack) begin
               r_key_code  <= w_code;
               r_key_valid <= 1'b1;
               if (key_ack) r_overrun <= 1'b0;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (key_ack && r_key_valid) begin
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
         end
      end
   end

   assign col_sel   = r_col_sel;
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan (4x4, SCAN_DIV=4, DEBOUNCE=3): keypad model on the rows, output-event scoreboard.
module tb_keypad_scan;

   localparam int ROWS = 4;
   localparam int COLS = 4;

   typedef struct packed {
      logic       v;
      logic [3:0] c;
      logic       o;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row_in;
   logic [3:0]  col_sel;
   logic        key_ack = 1'b0;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        overrun;
   logic [15:0] pressed = '0;

   int   cyc;
   int   n_chk  = 0;
   int   n_fail = 0;
   obs_t exp_q[$];
   obs_t prev = '0;

   always #5 clk = ~clk;

   keypad_scan #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE(3)
   ) dut (
      .clk(clk), .rst(rst), .row_in(row_in), .col_sel(col_sel),
      .key_ack(key_ack), .key_code(key_code), .key_valid(key_valid), .overrun(overrun)
   );

   // A closed key pulls its row low while its column strobe is active.
   always_comb begin
      row_in = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (pressed[r*COLS+c] && !col_sel[c]) row_in[r] = 1'b0;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      obs_t cur;
      obs_t e;
      cur = {key_valid, key_code, overrun};
      if (cur !== prev) begin
         prev = cur;
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got v=%0b code=%0d ovr=%0b, required no change", cur.v, cur.c, cur.o);
         end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
               n_fail++;
               $display("FAIL output_event: got v=%0b code=%0d ovr=%0b, required v=%0b code=%0d ovr=%0b",
                        cur.v, cur.c, cur.o, e.v, e.c, e.o);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic expect_out(input logic v, input logic [3:0] c, input logic o);
      exp_q.push_back({v, c, o});
   endtask

   task automatic wait_edge(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_valid(input int lim, output int at);
      at = -1;
      for (int k = 0; k < lim; k++) begin
         if (key_valid === 1'b1) begin
            at = cyc;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int r, input int c);
      pressed[r*COLS+c] = 1'b1;
   endtask

   initial begin
      logic [3:0] idle_exp [4];
      int at;
      idle_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_col_sel", col_sel, 4'b1110);
      check("reset_key_valid", key_valid, 1'b0);
      check("reset_key_code", key_code, 4'd0);
      check("reset_overrun", overrun, 1'b0);
      rst = 1'b1;

      for (int i = 0; i < 4; i++) begin
         wait_edge(4*(i+1));
         check("idle_col_sel", col_sel, idle_exp[i]);
      end

      // row2/col1 -> code 9
      expect_out(1'b1, 4'd9, 1'b0);
      press(2, 1);
      wait_valid(100, at);
      check("press_latency", at, 32);
      wait_edge(40);
      check("held_col_sel", col_sel, 4'b1101);
      pressed = '0;
      wait_edge(51);
      check("release_col_sel_hold", col_sel, 4'b1101);
      wait_edge(52);
      check("release_col_sel_adv", col_sel, 4'b1011);

      // one-sample bounce on row0/col3
      press(3 - 3, 3);
      wait_edge(60);
      check("bounce_col_stays", col_sel, 4'b0111);
      pressed = '0;
      wait_edge(64);
      check("bounce_resume_col0", col_sel, 4'b1110);

      // row1/col0 while 9 pending -> overrun
      expect_out(1'b1, 4'd9, 1'b1);
      press(1, 0);
      wait_edge(76);
      pressed = '0;
      wait_edge(88);
      check("overrun_release_col", col_sel, 4'b1101);
      wait_edge(90);
      expect_out(1'b0, 4'd9, 1'b0);
      key_ack = 1'b1;
      wait_edge(91);
      key_ack = 1'b0;

      // rows 1 and 3 in col2 -> lowest row wins, code 6
      expect_out(1'b1, 4'd6, 1'b0);
      press(1, 2);
      press(3, 2);
      wait_edge(104);
      pressed = '0;

      // row0/col0 while 6 pending -> overrun set again
      wait_edge(116);
      expect_out(1'b1, 4'd6, 1'b1);
      press(0, 0);
      wait_edge(132);
      pressed = '0;

      // row1/col1 emitted in the same cycle as ack -> code 5, overrun cleared
      wait_edge(144);
      expect_out(1'b1, 4'd5, 1'b0);
      press(1, 1);
      wait_edge(155);
      key_ack = 1'b1;
      wait_edge(156);
      key_ack = 1'b0;
      check("ack_emit_valid", key_valid, 1'b1);
      pressed = '0;

      // reset in the middle of debouncing row0/col2, key held through reset
      wait_edge(168);
      press(0, 2);
      wait_edge(174);
      expect_out(1'b0, 4'd0, 1'b0);
      rst = 1'b0;
      #1;
      check("midreset_col_sel", col_sel, 4'b1110);
      check("midreset_key_valid", key_valid, 1'b0);
      check("midreset_key_code", key_code, 4'd0);
      check("midreset_overrun", overrun, 1'b0);
      repeat (2) @(negedge clk);
      expect_out(1'b1, 4'd2, 1'b0);
      rst = 1'b1;
      wait_valid(100, at);
      check("post_reset_latency", at, 20);
      pressed = '0;
      repeat (20) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
